// File: rtl/addsub_pkg.sv
// Shared types and constants for the serial adder/subtractor.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic v;
        logic n;
        logic c;
        logic z;
    } flags_t;

endpackage

// File: rtl/addsub_digit.sv
// DIGIT-bit ripple-carry slice; also exposes the carry into its MSB for overflow detection.
module addsub_digit #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] a_d,
    input  logic [DIGIT-1:0] b_d,
    input  logic             cin,
    output logic [DIGIT-1:0] s_d,
    output logic             cout,
    output logic             c_top_in
);

    logic c;

    always_comb begin
        s_d      = '0;
        c_top_in = 1'b0;
        c        = cin;
        for (int i = 0; i < DIGIT; i++) begin
            if (i == DIGIT - 1) begin
                c_top_in = c;
            end
            s_d[i] = a_d[i] ^ b_d[i] ^ c;
            c      = (a_d[i] & b_d[i]) | (a_d[i] & c) | (b_d[i] & c);
        end
        cout = c;
    end

endmodule

// File: rtl/serial_addsub.sv
// Multi-cycle add/subtract with V/N/C/Z flags, DIGIT bits per clock behind valid/ready.
// Define SERIAL_ADDSUB_SAT_EN to saturate the result to the signed limit on overflow.
module serial_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             V,
    output logic             N,
    output logic             C,
    output logic             Z
);

    localparam int NSTEP = WIDTH / DIGIT;
    localparam int SW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
    localparam logic [SW-1:0] LAST = SW'(NSTEP - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             op_r;
    logic             carry;
    logic [SW-1:0]    step;
    logic [WIDTH-1:0] res_r;
    flags_t           flags_r;
    logic             out_valid_r;

    logic [DIGIT-1:0] s_d;
    logic             cout;
    logic             c_top_in;
    logic             v_raw;
    logic             c_flag;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] res_fin;

`ifdef SERIAL_ADDSUB_SAT_EN
    logic             a_msb;
`endif

    addsub_digit #(
        .DIGIT(DIGIT)
    ) u_digit (
        .a_d     (a_sh[DIGIT-1:0]),
        .b_d     (b_sh[DIGIT-1:0]),
        .cin     (carry),
        .s_d     (s_d),
        .cout    (cout),
        .c_top_in(c_top_in)
    );

    // res_fin is only meaningful on the last step, where the slice carries are the MSB's.
    always_comb begin
        res_next = res_r;
        res_next[int'(step)*DIGIT +: DIGIT] = s_d;
        v_raw    = c_top_in ^ cout;
        c_flag   = (op_r == OP_SUB) ? ~cout : cout;
        res_fin  = res_next;
`ifdef SERIAL_ADDSUB_SAT_EN
        if (v_raw) begin
            res_fin = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_sh        <= '0;
            b_sh        <= '0;
            op_r        <= 1'b0;
            carry       <= 1'b0;
            step        <= '0;
            res_r       <= '0;
            flags_r     <= '0;
            out_valid_r <= 1'b0;
`ifdef SERIAL_ADDSUB_SAT_EN
            a_msb       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= (op == OP_SUB) ? ~b : b;
                        op_r  <= op;
                        carry <= op;
                        step  <= '0;
                        state <= RUN;
`ifdef SERIAL_ADDSUB_SAT_EN
                        a_msb <= a[WIDTH-1];
`endif
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> DIGIT;
                    b_sh  <= b_sh >> DIGIT;
                    carry <= cout;
                    res_r <= res_next;
                    step  <= step + 1'b1;
                    if (step == LAST) begin
                        res_r       <= res_fin;
                        flags_r     <= '{v: v_raw, n: res_fin[WIDTH-1], c: c_flag, z: (res_fin == '0)};
                        out_valid_r <= 1'b1;
                        step        <= '0;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = out_valid_r;
    assign result    = res_r;
    assign V         = flags_r.v;
    assign N         = flags_r.n;
    assign C         = flags_r.c;
    assign Z         = flags_r.z;

endmodule
